// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-rate default, frame data width and the
// transmit serializer state encoding (also intended for the receiver).
package uart_pkg;

  localparam int unsigned UART_BAUD_DIV_DEFAULT = 434;
  localparam int unsigned UART_DATA_BITS        = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with registered occupancy count; depth must be a power of
// two so the pointers wrap naturally.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wr_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rd_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = i_push && !w_full;
  assign w_pop   = i_pop && !w_empty;

  // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full    = w_full;
  assign o_empty   = w_empty;
  assign o_count   = r_count;

endmodule

// File: rtl/uart_transmitter.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a start/data/stop
// serializer with a registered, idle-high line output.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = UART_BAUD_DIV_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [UART_DATA_BITS-1:0]     tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV);
  localparam int unsigned DW    = UART_DATA_BITS;
  localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(BAUD_DIV - 1);
  localparam logic [2:0]       LAST_BIT    = 3'(DW - 1);

  uart_tx_state_t     r_state;
  logic [CNT_W-1:0]   r_baud_cnt;
  logic [2:0]         r_bit_idx;
  logic [DW-1:0]      r_shift;
  logic               r_uart_tx;

  logic               w_push;
  logic               w_pop;
  logic               w_bit_done;
  logic [DW-1:0]      w_fifo_head;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] w_fifo_count;

  assign w_push     = tx_valid && tx_ready;
  assign w_bit_done = (r_baud_cnt == '0);
  // Pop when idle, or at the end of a stop bit so the next start follows with no gap.
  assign w_pop      = !w_fifo_empty &&
                      ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_done));

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_wr_data (tx_data),
    .i_pop     (w_pop),
    .o_rd_data (w_fifo_head),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_count   (w_fifo_count)
  );

  // Serializer: the line register is loaded with the value of the bit being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_uart_tx  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_uart_tx <= 1'b1;
          if (!w_fifo_empty) begin
            r_shift    <= w_fifo_head;
            r_baud_cnt <= BAUD_RELOAD;
            r_uart_tx  <= 1'b0;
            r_state    <= ST_START;
          end
        end
        ST_START: begin
          if (w_bit_done) begin
            r_baud_cnt <= BAUD_RELOAD;
            r_bit_idx  <= '0;
            r_uart_tx  <= r_shift[0];
            r_state    <= ST_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt - CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (w_bit_done) begin
            r_baud_cnt <= BAUD_RELOAD;
            r_shift    <= {1'b0, r_shift[DW-1:1]};
            if (r_bit_idx == LAST_BIT) begin
              r_uart_tx <= 1'b1;
              r_state   <= ST_STOP;
            end else begin
              r_uart_tx <= r_shift[1];
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt - CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (w_bit_done) begin
            if (!w_fifo_empty) begin
              r_shift    <= w_fifo_head;
              r_baud_cnt <= BAUD_RELOAD;
              r_uart_tx  <= 1'b0;
              r_state    <= ST_START;
            end else begin
              r_uart_tx <= 1'b1;
              r_state   <= ST_IDLE;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_uart_tx <= 1'b1;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign uart_tx    = r_uart_tx;
  assign tx_ready   = !w_fifo_full;
  assign busy       = (r_state != ST_IDLE) || !w_fifo_empty;
  assign fifo_count = w_fifo_count;

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Buffered 8N1 UART transmitter that serializes bytes written by the CPU-side bus logic onto the `uart_tx` line. A small FIFO decouples the byte producer from the bit-rate serializer, so firmware can burst several bytes without stalling. It is the transmit end of the console path whose receive end is the simulation UART decoder, `uart_decoder`. Both ends share `BAUD_DIV = 434`.

## Interface
Parameters:
- `BAUD_DIV`, default 434: clock cycles per UART bit; legal values are ≥ 2.
- `FIFO_DEPTH`, default 16: transmit FIFO entries; must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tx_data`  in  8  byte to send.
- `tx_valid`  in  1  producer offers `tx_data`.
- `tx_ready`  out  1  FIFO can accept a byte (`fifo_count < FIFO_DEPTH`).
- `uart_tx`  out  1  serial line; idles high; registered output.
- `busy`  out  1  high when the serializer is not IDLE or the FIFO is non-empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  bytes currently queued, excluding the byte being shifted.

## Operation
- **Accept:** a byte is written on the rising edge where `tx_valid && tx_ready` is true. `tx_data` is ignored when `tx_valid` is low.
- **FIFO:** first in, first out. Read and write pointers wrap modulo `FIFO_DEPTH`. When a push and a pop happen in the same cycle, `fifo_count` is unchanged.
- **Serializer FSM states:** IDLE, START, DATA, STOP. A baud counter counts down from `BAUD_DIV-1` to 0; each bit is held for exactly `BAUD_DIV` cycles.
  - **IDLE:** `uart_tx` = 1. If the FIFO is non-empty, pop the head byte into the shift register and go to START.
  - **START:** `uart_tx` = 0 for one bit time, then go to DATA.
  - **DATA:** send 8 bits LSB first. Shift right at the end of each bit time. The bit index runs 0..7; after bit 7, go to STOP.
  - **STOP:** `uart_tx` = 1 for one bit time. At the end:
    - if the FIFO is non-empty, pop and go directly to START, with no idle gap;
    - otherwise go to IDLE.
- **Frame:** exactly `10*BAUD_DIV` cycles. Frames sent back-to-back are contiguous.
- **Arithmetic:** the baud counter is $clog2(BAUD_DIV) bits wide. The bit index is 3 bits. `fifo_count` never exceeds `FIFO_DEPTH`.
- **Boundary cases:**
  - Push while full is impossible, because `tx_ready` is low.
  - A pop while full frees space; `tx_ready` rises on the following cycle, not combinationally in the same cycle.
  - Pop while empty never occurs.

## Timing
- **Reset values:** `uart_tx`=1, `tx_ready`=1, `busy`=0, `fifo_count`=0, FSM in IDLE, FIFO pointers at 0.
- **Reset mid-frame:** asserting `rst_n` forces `uart_tx` high asynchronously. The FIFO is flushed and the partial frame is abandoned. Nothing resumes after release.
- **Latency:** with the FIFO empty and the FSM in IDLE, a byte accepted at edge N is popped at edge N+1. `uart_tx` falls after edge N+1, so the start bit begins 2 cycles after the request cycle.
- **`fifo_count` and `tx_ready`:** both are registered, or derived only from registered counts, and update one cycle after the event.
- **`busy`:** falls in the same cycle the FSM enters IDLE with the FIFO empty, i.e. right after the last stop bit completes.

## Structure
- Shared package `uart_pkg`:
  - `UART_BAUD_DIV_DEFAULT` = 434;
  - `UART_DATA_BITS` = 8;
  - FSM state encoding `uart_tx_state_t`.

  `uart_pkg` is also used by a future receiver.
- Sub-module `uart_tx_fifo`: a synchronous FIFO parameterized by depth and width. It has push/pop/full/empty/count signals and an async active-low reset.
- Top-level `uart_transmitter` holds the FSM, baud counter, shift register and output register.

## Test plan
- **Single byte:** `BAUD_DIV`=8, push 0x55 → `uart_tx` sequence 0,1,0,1,0,1,0,1,0,1,1, each bit held for 8 cycles. The start bit begins 2 cycles after the accept cycle, and `busy` drops after 80 cycles.
- **Back-to-back:** `BAUD_DIV`=8, push 0x41 then 0x42 on consecutive cycles → 160 contiguous line cycles. Stop bit 1 is followed immediately by start bit 2, and the data bits are LSB first.
- **Backpressure:** `FIFO_DEPTH`=4, hold `tx_valid` high with 0x00..0x09 → exactly 5 accepts occur before `tx_ready` drops (one byte is already in the serializer). `tx_ready` rises one cycle after each pop, and all 10 bytes are sent in order.
- **Reset mid-frame:** push 0xA5 and 0x3C, then assert `rst_n` low during DATA bit 3 → `uart_tx`=1 immediately and `fifo_count`=0. After release, the line stays high with no further frames.
- **Loopback:** `BAUD_DIV`=434, drive `uart_tx` into `uart_decoder` and push "Hi\n" → the decoder prints "Hi\n".
- **Idle check:** `tx_valid` held low for 10000 cycles → `uart_tx` stays 1 and `busy` stays 0 throughout.
